// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
//   Round-robin arbiter that shares the single write port of an async FIFO
//   (write-clock domain) among NUM_REQ requesters. A requester is granted for
//   a burst of up to MAX_BURST words. The arbiter stalls on wfull and drives
//   winc/wdata straight into the FIFO write side.
//
// Ports
//   clk        in   write-domain clock (FIFO wclk)
//   rst_n      in   synchronous active-low reset
//   arb_en     in   1 = new grants allowed; 0 = the current burst still finishes
//   req_valid  in   per-requester word valid
//   req_data   in   requester i word in bits [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready  out  one-hot/zero; word i is accepted on req_valid[i] & req_ready[i]
//   wfull      in   FIFO full flag
//   winc       out  FIFO write enable
//   wdata      out  FIFO write data
//   gnt_id     out  index of the current grant holder (meaningful while busy)
//   busy       out  1 while a grant is held
// -----------------------------------------------------------------------------
module fifo_wr_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int MAX_BURST  = 4,
  localparam int ID_W      = $clog2(NUM_REQ),
  localparam int CNT_W     = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          arb_en,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          wfull,
  output logic                          winc,
  output logic [DATA_WIDTH-1:0]         wdata,
  output logic [ID_W-1:0]               gnt_id,
  output logic                          busy
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t           state_q;
  logic [ID_W-1:0]  gnt_id_q;
  logic [ID_W-1:0]  rr_ptr_q;
  logic [CNT_W-1:0] burst_cnt_q;

  logic             pick_found_d;
  logic [ID_W-1:0]  pick_idx_d;
  logic             cur_valid;
  logic             last_word;

  // Explicit wrap so non-power-of-two NUM_REQ never produces an invalid index.
  function automatic logic [ID_W-1:0] next_idx(input logic [ID_W-1:0] id);
    if (id == ID_W'(NUM_REQ - 1)) return '0;
    return id + 1'b1;
  endfunction

  // First valid requester scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  always_comb begin
    int unsigned idx;
    pick_found_d = 1'b0;
    pick_idx_d   = '0;
    idx          = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(rr_ptr_q) + i) % NUM_REQ;
      if (!pick_found_d && req_valid[idx]) begin
        pick_found_d = 1'b1;
        pick_idx_d   = ID_W'(idx);
      end
    end
  end

  assign busy      = (state_q == GRANT);
  assign cur_valid = req_valid[gnt_id_q];
  // Outputs are also gated by rst_n so that no word is written or accepted in
  // the cycle a reset abandons a burst.
  assign winc      = rst_n & busy & ~wfull & cur_valid;
  assign req_ready = (rst_n & busy & ~wfull) ? (NUM_REQ'(1) << gnt_id_q) : '0;
  assign wdata     = req_data[gnt_id_q*DATA_WIDTH +: DATA_WIDTH];
  assign gnt_id    = gnt_id_q;
  assign last_word = (burst_cnt_q == CNT_W'(MAX_BURST - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      gnt_id_q    <= '0;
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (arb_en && pick_found_d) begin
            gnt_id_q    <= pick_idx_d;
            burst_cnt_q <= '0;
            state_q     <= GRANT;
          end
        end
        GRANT: begin
          if (winc) begin
            if (last_word) begin
              state_q  <= IDLE;
              rr_ptr_q <= next_idx(gnt_id_q);
            end else begin
              burst_cnt_q <= burst_cnt_q + 1'b1;
            end
          end else if (!cur_valid) begin
            // Holder ran dry: release early and give others a turn.
            state_q  <= IDLE;
            rr_ptr_q <= next_idx(gnt_id_q);
          end
          // Otherwise wfull stall: grant and burst count held.
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
